// File: rtl/xgmac_pkg.sv
// Shared definitions for the 10G MAC transmit feeder: bus widths, FSM encoding
// and byte-residue helpers used by both the length calculator and the framer.
package xgmac_pkg;

    localparam int C_AXIS_W = 64;
    localparam int C_KEEP_W = 8;
    localparam int C_LEN_W  = 14;
    localparam int C_WCNT_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_SEND  = 2'd2,
        ST_DRAIN = 2'd3
    } tx_state_e;

    // Residue 0 means a completely filled last beat.
    function automatic logic [C_KEEP_W-1:0] residue_to_keep(input logic [2:0] residue);
        logic [C_KEEP_W-1:0] keep;
        case (residue)
            3'd0:    keep = 8'hFF;
            3'd1:    keep = 8'h01;
            3'd2:    keep = 8'h03;
            3'd3:    keep = 8'h07;
            3'd4:    keep = 8'h0F;
            3'd5:    keep = 8'h1F;
            3'd6:    keep = 8'h3F;
            3'd7:    keep = 8'h7F;
            default: keep = 8'hFF;
        endcase
        return keep;
    endfunction

    function automatic logic [C_AXIS_W-1:0] keep_to_mask(input logic [C_KEEP_W-1:0] keep);
        logic [C_AXIS_W-1:0] mask;
        mask = {C_AXIS_W{1'b0}};
        for (int i = 0; i < C_KEEP_W; i++) begin
            mask[i*8 +: 8] = {8{keep[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/xgmac_tx_lencalc.sv
// Derives legality, word counts and last-beat byte enables from a frame length.
// Legality is combinational for the accept decision; the rest is captured on load.
module xgmac_tx_lencalc
    import xgmac_pkg::*;
#(
    parameter int C_MIN_LEN = 60,
    parameter int C_MAX_LEN = 9600,
    parameter int C_PAD_EN  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic [C_LEN_W-1:0]  i_len,
    output logic                o_legal,
    output logic [C_WCNT_W-1:0] o_src_words,
    output logic [C_WCNT_W-1:0] o_tot_words,
    output logic [C_KEEP_W-1:0] o_last_keep,
    output logic [C_KEEP_W-1:0] o_last_mask
);

    localparam logic [C_LEN_W-1:0] C_MIN_L = C_LEN_W'(C_MIN_LEN);
    localparam logic [C_LEN_W-1:0] C_MAX_L = C_LEN_W'(C_MAX_LEN);
    localparam logic               C_PAD_B = (C_PAD_EN != 0);

    logic                 w_legal;
    logic                 w_pad;
    logic [C_LEN_W-1:0]   w_eff_len;
    logic [C_LEN_W:0]     w_src_sum;
    logic [C_LEN_W:0]     w_tot_sum;
    logic [C_KEEP_W-1:0]  w_last_keep;
    logic [C_KEEP_W-1:0]  w_last_mask;

    logic [C_WCNT_W-1:0]  r_src_words;
    logic [C_WCNT_W-1:0]  r_tot_words;
    logic [C_KEEP_W-1:0]  r_last_keep;
    logic [C_KEEP_W-1:0]  r_last_mask;

    // Length arithmetic; the source mask zeroes bytes past cmd_len only for padded runts.
    always_comb begin
        w_legal     = (i_len != {C_LEN_W{1'b0}}) && (i_len <= C_MAX_L);
        w_pad       = C_PAD_B && (i_len < C_MIN_L);
        w_eff_len   = w_pad ? C_MIN_L : i_len;
        w_src_sum   = {1'b0, i_len} + 15'd7;
        w_tot_sum   = {1'b0, w_eff_len} + 15'd7;
        w_last_keep = residue_to_keep(w_eff_len[2:0]);
        w_last_mask = w_pad ? residue_to_keep(i_len[2:0]) : 8'hFF;
    end

    // Capture the derived frame geometry on command acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_words <= {C_WCNT_W{1'b0}};
            r_tot_words <= {C_WCNT_W{1'b0}};
            r_last_keep <= 8'h00;
            r_last_mask <= 8'h00;
        end else if (i_load) begin
            r_src_words <= w_src_sum[C_LEN_W:3];
            r_tot_words <= w_tot_sum[C_LEN_W:3];
            r_last_keep <= w_last_keep;
            r_last_mask <= w_last_mask;
        end
    end

    assign o_legal     = w_legal;
    assign o_src_words = r_src_words;
    assign o_tot_words = r_tot_words;
    assign o_last_keep = r_last_keep;
    assign o_last_mask = r_last_mask;

endmodule

// File: rtl/xgmac_tx_feeder.sv
// AXI4-Stream framer for the 10G MAC transmit path: frames an unframed word source
// by byte length, pads runts, and aborts with tuser if the source starves mid-frame.
module xgmac_tx_feeder
    import xgmac_pkg::*;
#(
    parameter int C_MIN_LEN = 60,
    parameter int C_MAX_LEN = 9600,
    parameter int C_PAD_EN  = 1
) (
    input  logic                clk156,
    input  logic                tx_axis_aresetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [C_LEN_W-1:0]  cmd_len,
    input  logic [C_AXIS_W-1:0] src_tdata,
    input  logic                src_tvalid,
    output logic                src_tready,
    output logic [C_AXIS_W-1:0] tx_axis_tdata,
    output logic [C_KEEP_W-1:0] tx_axis_tkeep,
    output logic                tx_axis_tvalid,
    output logic                tx_axis_tlast,
    output logic                tx_axis_tuser,
    input  logic                tx_axis_tready,
    output logic                frame_done,
    output logic                underrun,
    output logic                len_err,
    output logic [31:0]         frame_cnt
);

    tx_state_e            r_state;
    tx_state_e            w_state_nxt;
    logic                 r_cmd_ready;
    logic [C_WCNT_W-1:0]  r_src_cnt;
    logic [C_WCNT_W-1:0]  r_beat_cnt;
    logic [C_AXIS_W-1:0]  r_tdata;
    logic [C_KEEP_W-1:0]  r_tkeep;
    logic                 r_tvalid;
    logic                 r_tlast;
    logic                 r_tuser;
    logic                 r_frame_done;
    logic                 r_underrun;
    logic                 r_len_err;
    logic [31:0]          r_frame_cnt;

    logic                 w_legal;
    logic [C_WCNT_W-1:0]  w_src_words;
    logic [C_WCNT_W-1:0]  w_tot_words;
    logic [C_KEEP_W-1:0]  w_last_keep;
    logic [C_KEEP_W-1:0]  w_last_mask;

    logic                 w_adv;
    logic                 w_cmd_hs;
    logic                 w_tx_hs;
    logic                 w_src_left;
    logic                 w_src_last;
    logic                 w_beat_last;
    logic [C_AXIS_W-1:0]  w_src_word;
    logic [C_KEEP_W-1:0]  w_word_keep;

    logic                 w_src_tready;
    logic                 w_take;
    logic                 w_start;
    logic                 w_load;
    logic [C_AXIS_W-1:0]  w_ld_data;
    logic [C_KEEP_W-1:0]  w_ld_keep;
    logic                 w_ld_last;
    logic                 w_ld_user;
    logic                 w_underrun;
    logic                 w_len_err;

    xgmac_tx_lencalc #(
        .C_MIN_LEN (C_MIN_LEN),
        .C_MAX_LEN (C_MAX_LEN),
        .C_PAD_EN  (C_PAD_EN)
    ) u_lencalc (
        .clk         (clk156),
        .rst_n       (tx_axis_aresetn),
        .i_load      (w_cmd_hs),
        .i_len       (cmd_len),
        .o_legal     (w_legal),
        .o_src_words (w_src_words),
        .o_tot_words (w_tot_words),
        .o_last_keep (w_last_keep),
        .o_last_mask (w_last_mask)
    );

    // Handshake qualifiers and the per-beat view of the current source word.
    always_comb begin
        w_adv       = !r_tvalid || tx_axis_tready;
        w_cmd_hs    = r_cmd_ready && cmd_valid;
        w_tx_hs     = r_tvalid && tx_axis_tready;
        w_src_left  = (r_src_cnt < w_src_words);
        w_src_last  = (r_src_cnt == (w_src_words - 12'd1));
        w_beat_last = (r_beat_cnt == (w_tot_words - 12'd1));
        w_word_keep = w_beat_last ? w_last_keep : 8'hFF;
        w_src_word  = w_src_last ? (src_tdata & keep_to_mask(w_last_mask)) : src_tdata;
    end

    // Next-state and beat-load decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_src_tready = 1'b0;
        w_take       = 1'b0;
        w_start      = 1'b0;
        w_load       = 1'b0;
        w_ld_data    = {C_AXIS_W{1'b0}};
        w_ld_keep    = 8'h00;
        w_ld_last    = 1'b0;
        w_ld_user    = 1'b0;
        w_underrun   = 1'b0;
        w_len_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_hs && w_legal) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_FIRST;
                end else if (w_cmd_hs) begin
                    w_len_err   = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FIRST: begin
                w_src_tready = w_adv;
                if (w_adv && src_tvalid) begin
                    w_take      = 1'b1;
                    w_load      = 1'b1;
                    w_ld_data   = w_src_word;
                    w_ld_keep   = w_word_keep;
                    w_ld_last   = w_beat_last;
                    w_state_nxt = w_beat_last ? ST_IDLE : ST_SEND;
                end else begin
                    w_state_nxt = ST_FIRST;
                end
            end
            ST_SEND: begin
                // A starved source is only judged on cycles the output could advance.
                if (w_src_left) begin
                    w_src_tready = w_adv;
                    if (w_adv && src_tvalid) begin
                        w_take      = 1'b1;
                        w_load      = 1'b1;
                        w_ld_data   = w_src_word;
                        w_ld_keep   = w_word_keep;
                        w_ld_last   = w_beat_last;
                        w_state_nxt = w_beat_last ? ST_IDLE : ST_SEND;
                    end else if (w_adv) begin
                        w_load      = 1'b1;
                        w_ld_keep   = 8'hFF;
                        w_ld_last   = 1'b1;
                        w_ld_user   = 1'b1;
                        w_underrun  = 1'b1;
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_SEND;
                    end
                end else if (w_adv) begin
                    w_load      = 1'b1;
                    w_ld_keep   = w_word_keep;
                    w_ld_last   = w_beat_last;
                    w_state_nxt = w_beat_last ? ST_IDLE : ST_SEND;
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_DRAIN: begin
                w_src_tready = 1'b1;
                if (src_tvalid) begin
                    w_take      = 1'b1;
                    w_state_nxt = w_src_last ? ST_IDLE : ST_DRAIN;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, counters, output register and status pulses.
    always_ff @(posedge clk156 or negedge tx_axis_aresetn) begin
        if (!tx_axis_aresetn) begin
            r_state      <= ST_IDLE;
            r_cmd_ready  <= 1'b0;
            r_src_cnt    <= {C_WCNT_W{1'b0}};
            r_beat_cnt   <= {C_WCNT_W{1'b0}};
            r_tdata      <= {C_AXIS_W{1'b0}};
            r_tkeep      <= 8'h00;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_tuser      <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
            r_len_err    <= 1'b0;
            r_frame_cnt  <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            if (w_start) begin
                r_src_cnt  <= {C_WCNT_W{1'b0}};
                r_beat_cnt <= {C_WCNT_W{1'b0}};
            end else begin
                r_src_cnt  <= w_take ? (r_src_cnt + 12'd1) : r_src_cnt;
                r_beat_cnt <= w_load ? (r_beat_cnt + 12'd1) : r_beat_cnt;
            end
            if (w_adv) begin
                r_tvalid <= w_load;
                r_tdata  <= w_ld_data;
                r_tkeep  <= w_ld_keep;
                r_tlast  <= w_ld_last;
                r_tuser  <= w_ld_user;
            end
            r_frame_done <= w_tx_hs && r_tlast && !r_tuser;
            r_frame_cnt  <= (w_tx_hs && r_tlast && !r_tuser) ? (r_frame_cnt + 32'd1) : r_frame_cnt;
            r_underrun   <= w_underrun;
            r_len_err    <= w_len_err;
        end
    end

    assign cmd_ready      = r_cmd_ready;
    assign src_tready     = w_src_tready;
    assign tx_axis_tdata  = r_tdata;
    assign tx_axis_tkeep  = r_tkeep;
    assign tx_axis_tvalid = r_tvalid;
    assign tx_axis_tlast  = r_tlast;
    assign tx_axis_tuser  = r_tuser;
    assign frame_done     = r_frame_done;
    assign underrun       = r_underrun;
    assign len_err        = r_len_err;
    assign frame_cnt      = r_frame_cnt;

endmodule

// File: tb/tb_xgmac_tx_feeder.sv
// Directed self-checking bench for xgmac_tx_feeder: framing, padding, backpressure,
// underrun abort/drain, illegal lengths and asynchronous reset mid-frame.
module tb_xgmac_tx_feeder;

    logic        clk156 = 1'b0;
    logic        tx_axis_aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [13:0] cmd_len;
    logic [63:0] src_tdata;
    logic        src_tvalid;
    logic        src_tready;
    logic [63:0] tx_axis_tdata;
    logic [7:0]  tx_axis_tkeep;
    logic        tx_axis_tvalid;
    logic        tx_axis_tlast;
    logic        tx_axis_tuser;
    logic        tx_axis_tready;
    logic        frame_done;
    logic        underrun;
    logic        len_err;
    logic [31:0] frame_cnt;

    always #5 clk156 = ~clk156;

    xgmac_tx_feeder #(
        .C_MIN_LEN (60),
        .C_MAX_LEN (9600),
        .C_PAD_EN  (1)
    ) dut (
        .clk156          (clk156),
        .tx_axis_aresetn (tx_axis_aresetn),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_len         (cmd_len),
        .src_tdata       (src_tdata),
        .src_tvalid      (src_tvalid),
        .src_tready      (src_tready),
        .tx_axis_tdata   (tx_axis_tdata),
        .tx_axis_tkeep   (tx_axis_tkeep),
        .tx_axis_tvalid  (tx_axis_tvalid),
        .tx_axis_tlast   (tx_axis_tlast),
        .tx_axis_tuser   (tx_axis_tuser),
        .tx_axis_tready  (tx_axis_tready),
        .frame_done      (frame_done),
        .underrun        (underrun),
        .len_err         (len_err),
        .frame_cnt       (frame_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Source / sink control shared with the driver process.
    bit src_en        = 1'b0;
    int src_idx       = 0;
    int src_limit     = 0;
    int src_drop_at   = -1;
    bit dropped       = 1'b0;
    bit tready_toggle = 1'b0;

    // Monitor state.
    logic [63:0] cap_data[$];
    logic [7:0]  cap_keep[$];
    logic        cap_last[$];
    logic        cap_user[$];
    int n_done = 0, n_under = 0, n_lenerr = 0, n_take = 0, n_tlast = 0, n_tvcyc = 0;
    int cyc = 0, hs_cyc = 0, fv_cyc = 0;
    bit fv_seen = 1'b0;
    bit prev_stall = 1'b0;
    logic [74:0] stall_vec;
    int stall_viol = 0;

    function automatic logic [63:0] word(input int idx);
        logic [63:0] w;
        w = 64'd0;
        for (int k = 0; k < 8; k++) begin
            w[k*8 +: 8] = 8'h80 | 8'((idx * 8 + k) & 127);
        end
        return w;
    endfunction

    function automatic logic [73:0] exp_beat(input int len, input int tot, input logic [7:0] lkeep, input int b);
        int          sw;
        int          res;
        logic [63:0] d;
        logic        last;
        sw   = (len + 7) / 8;
        res  = len % 8;
        d    = 64'd0;
        if (b < sw) begin
            d = word(b);
            if (b == sw - 1 && len < 60 && res != 0) begin
                for (int k = 0; k < 8; k++) begin
                    if (k >= res) d[k*8 +: 8] = 8'h00;
                end
            end
        end
        last = (b == tot - 1);
        return {d, (last ? lkeep : 8'hFF), last, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Source and tready driver: inputs change 1 time unit after the rising edge.
    initial begin
        bit take;
        src_tvalid     = 1'b0;
        src_tdata      = 64'd0;
        tx_axis_tready = 1'b1;
        forever begin
            @(negedge clk156);
            take = src_tvalid && src_tready;
            @(posedge clk156);
            #1;
            if (take) src_idx++;
            tx_axis_tready = tready_toggle ? ~tx_axis_tready : 1'b1;
            if (src_en && src_idx < src_limit && !(src_idx == src_drop_at && !dropped)) begin
                src_tvalid = 1'b1;
                src_tdata  = word(src_idx);
            end else begin
                if (src_en && src_idx == src_drop_at) dropped = 1'b1;
                src_tvalid = 1'b0;
                src_tdata  = 64'd0;
            end
        end
    end

    // Monitor sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk156);
            cyc++;
            if (prev_stall && {tx_axis_tdata, tx_axis_tkeep, tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser} !== stall_vec)
                stall_viol++;
            prev_stall = tx_axis_tvalid && !tx_axis_tready && tx_axis_aresetn;
            stall_vec  = {tx_axis_tdata, tx_axis_tkeep, tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser};
            if (tx_axis_tvalid && tx_axis_tready) begin
                cap_data.push_back(tx_axis_tdata);
                cap_keep.push_back(tx_axis_tkeep);
                cap_last.push_back(tx_axis_tlast);
                cap_user.push_back(tx_axis_tuser);
                if (tx_axis_tlast) n_tlast++;
            end
            if (tx_axis_tvalid) n_tvcyc++;
            if (frame_done) n_done++;
            if (underrun) n_under++;
            if (len_err) n_lenerr++;
            if (src_tvalid && src_tready) n_take++;
            if (cmd_valid && cmd_ready) begin
                hs_cyc  = cyc;
                fv_seen = 1'b0;
            end
            if (tx_axis_tvalid && !fv_seen) begin
                fv_cyc  = cyc;
                fv_seen = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic start_frame(input string tag, input int len, input int nprov, input int drop_at, input bit toggle);
        bit hs;
        @(posedge clk156);
        #2;
        cap_data.delete(); cap_keep.delete(); cap_last.delete(); cap_user.delete();
        n_done = 0; n_under = 0; n_lenerr = 0; n_take = 0; n_tlast = 0; n_tvcyc = 0; stall_viol = 0;
        src_idx = 0; dropped = 1'b0; src_limit = nprov; src_drop_at = drop_at;
        tready_toggle = toggle; src_en = 1'b1;
        cmd_len = 14'(len); cmd_valid = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk156);
            if (cmd_valid && cmd_ready) begin
                hs = 1'b1;
                break;
            end
        end
        @(posedge clk156);
        #1;
        cmd_valid = 1'b0;
        check({tag, "_cmd_hs"}, 80'(hs), 80'd1);
    endtask

    task automatic finish_frame(input string tag);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk156);
            if (n_tlast > 0) break;
        end
        check({tag, "_tlast_seen"}, 80'(n_tlast), 80'd1);
        repeat (40) @(negedge clk156);
        @(posedge clk156);
        #2;
        src_en = 1'b0;
        tready_toggle = 1'b0;
    endtask

    task automatic check_beats(input string tag, input int len, input int tot, input logic [7:0] lkeep);
        int n;
        check({tag, "_beats"}, 80'(cap_data.size()), 80'(tot));
        n = (cap_data.size() < tot) ? cap_data.size() : tot;
        for (int b = 0; b < n; b++) begin
            check($sformatf("%s_beat%0d", tag, b),
                  80'({cap_data[b], cap_keep[b], cap_last[b], cap_user[b]}),
                  80'(exp_beat(len, tot, lkeep, b)));
        end
    endtask

    initial begin
        tx_axis_aresetn = 1'b0;
        cmd_valid       = 1'b0;
        cmd_len         = 14'd0;
        #23;
        check("reset_outputs",
              {cmd_ready, src_tready, tx_axis_tdata, tx_axis_tkeep, tx_axis_tvalid, tx_axis_tlast,
               tx_axis_tuser, frame_done, underrun, len_err}, 80'd0);
        check("reset_frame_cnt", 80'(frame_cnt), 80'd0);
        @(posedge clk156);
        #2;
        tx_axis_aresetn = 1'b1;
        repeat (2) @(negedge clk156);
        check("idle_cmd_ready", 80'(cmd_ready), 80'd1);

        // 64 bytes: 8 full beats, 2-cycle command-to-tvalid latency.
        start_frame("len64", 64, 8, -1, 1'b0);
        finish_frame("len64");
        check_beats("len64", 64, 8, 8'hFF);
        check("len64_latency", 80'(fv_cyc - hs_cyc), 80'd2);
        check("len64_done", 80'(n_done), 80'd1);
        check("len64_cnt", 80'(frame_cnt), 80'd1);
        check("len64_take", 80'(n_take), 80'd8);

        // 42 bytes padded to 60: 6 source words, 2 pad beats, last tkeep 0x0F.
        start_frame("len42", 42, 6, -1, 1'b0);
        finish_frame("len42");
        check_beats("len42", 42, 8, 8'h0F);
        check("len42_keep_last", 80'(cap_keep[7]), 80'h0F);
        check("len42_take", 80'(n_take), 80'd6);
        check("len42_cnt", 80'(frame_cnt), 80'd2);

        // 1514 bytes with tready toggling: 190 beats, stable outputs while stalled.
        start_frame("len1514", 1514, 190, -1, 1'b1);
        finish_frame("len1514");
        check_beats("len1514", 1514, 190, 8'h03);
        check("len1514_stall_stable", 80'(stall_viol), 80'd0);
        check("len1514_underrun", 80'(n_under), 80'd0);
        check("len1514_cnt", 80'(frame_cnt), 80'd3);

        // 256 bytes, source drops after 10 words: abort beat, drain of the 22 remaining.
        start_frame("abort", 256, 32, 10, 1'b0);
        finish_frame("abort");
        check("abort_beats", 80'(cap_data.size()), 80'd11);
        for (int b = 0; b < 10 && b < cap_data.size(); b++) begin
            check($sformatf("abort_beat%0d", b),
                  80'({cap_data[b], cap_keep[b], cap_last[b], cap_user[b]}),
                  80'({word(b), 8'hFF, 1'b0, 1'b0}));
        end
        if (cap_data.size() > 10)
            check("abort_beat10", 80'({cap_data[10], cap_keep[10], cap_last[10], cap_user[10]}),
                  80'({64'd0, 8'hFF, 1'b1, 1'b1}));
        check("abort_underrun", 80'(n_under), 80'd1);
        check("abort_take", 80'(n_take), 80'd32);
        check("abort_done", 80'(n_done), 80'd0);
        check("abort_cnt", 80'(frame_cnt), 80'd3);

        start_frame("post_abort", 64, 8, -1, 1'b0);
        finish_frame("post_abort");
        check_beats("post_abort", 64, 8, 8'hFF);
        check("post_abort_cnt", 80'(frame_cnt), 80'd4);

        // Illegal lengths 0 and 9601: len_err twice, no source or MAC activity.
        start_frame("len0", 0, 4, -1, 1'b0);
        repeat (8) @(negedge clk156);
        check("len0_lenerr", 80'(n_lenerr), 80'd1);
        @(posedge clk156);
        #2;
        cmd_len = 14'd9601; cmd_valid = 1'b1;
        @(negedge clk156);
        check("len9601_cmd_ready", 80'(cmd_ready), 80'd1);
        @(posedge clk156);
        #1;
        cmd_valid = 1'b0;
        repeat (8) @(negedge clk156);
        check("lenerr_pulses", 80'(n_lenerr), 80'd2);
        check("lenerr_take", 80'(n_take), 80'd0);
        check("lenerr_tvalid", 80'(n_tvcyc), 80'd0);
        check("lenerr_cnt", 80'(frame_cnt), 80'd4);
        @(posedge clk156);
        #2;
        src_en = 1'b0;

        // Asynchronous reset on beat 5 of a 128-byte frame.
        start_frame("rst", 128, 16, -1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk156);
            if (cap_data.size() >= 4) break;
        end
        #2;
        tx_axis_aresetn = 1'b0;
        #1;
        check("rst_async_outputs",
              {cmd_ready, src_tready, tx_axis_tdata, tx_axis_tkeep, tx_axis_tvalid, tx_axis_tlast,
               tx_axis_tuser, frame_done, underrun, len_err}, 80'd0);
        check("rst_async_cnt", 80'(frame_cnt), 80'd0);
        src_en = 1'b0;
        repeat (2) @(posedge clk156);
        #2;
        tx_axis_aresetn = 1'b1;
        repeat (2) @(negedge clk156);

        start_frame("post_rst", 64, 8, -1, 1'b0);
        finish_frame("post_rst");
        check_beats("post_rst", 64, 8, 8'hFF);
        check("post_rst_done", 80'(n_done), 80'd1);
        check("post_rst_cnt", 80'(frame_cnt), 80'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
